// File: rtl/systolic_pkg.sv
// Shared types and default parameter values for the systolic array blocks.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_MATRIX_SIZE = 3;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_OUT_WIDTH   = 8;

  // Drain controller state: waiting for a snapshot, or streaming it out.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/requant_sat.sv
// Requantizer: rounding arithmetic right shift followed by saturation to a
// signed OUT_WIDTH result. Purely combinational.
module requant_sat #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [OUT_WIDTH-1:0]   data,
  output logic                          sat
);

  // One extra bit of headroom so adding the rounding constant cannot overflow.
  localparam logic signed [ACC_WIDTH:0] MAX_VAL =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_VAL =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] wide;
  logic signed [ACC_WIDTH:0] rnd;
  logic signed [ACC_WIDTH:0] shifted;

  // Round half up, shift, then clamp into the output range.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rnd  = '0;
    sat  = 1'b0;
    wide = {acc[ACC_WIDTH-1], acc};
    if (shift != '0) rnd[shift - 1'b1] = 1'b1;
    shifted = (wide + rnd) >>> shift;
    data    = shifted[OUT_WIDTH-1:0];
    if (shifted > MAX_VAL) begin
      data = MAX_VAL[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_VAL) begin
      data = MIN_VAL[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/acc_drain_unit.sv
// Accumulator drain unit: snapshots the N*N accumulator bank of a systolic
// array on request and streams the requantized elements out in row-major
// order over a valid/ready interface.
module acc_drain_unit
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] acc_out_flat,
  input  logic                                         capture,
  input  logic [$clog2(ACC_WIDTH)-1:0]                 shift_amt,
  input  logic                                         out_ready,
  output logic                                         out_valid,
  output logic [OUT_WIDTH-1:0]                         out_data,
  output logic [$clog2(MATRIX_SIZE)-1:0]               out_row,
  output logic [$clog2(MATRIX_SIZE)-1:0]               out_col,
  output logic                                         out_last,
  output logic                                         out_sat,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         capture_drop
);

  localparam int N     = MATRIX_SIZE;
  localparam int NUM   = N * N;
  localparam int IDX_W = $clog2(NUM);
  localparam int RC_W  = $clog2(N);
  localparam int SH_W  = $clog2(ACC_WIDTH);

  // The accumulator must hold at least a full operand product.
  if (ACC_WIDTH < 2 * DATA_WIDTH || ACC_WIDTH < OUT_WIDTH) begin : g_bad_params
    $error("acc_drain_unit: ACC_WIDTH too narrow for DATA_WIDTH/OUT_WIDTH");
  end

  drain_state_t         state;
  logic [IDX_W-1:0]     idx;
  logic [ACC_WIDTH-1:0] snap [NUM];
  logic [SH_W-1:0]      snap_shift;

  logic [IDX_W-1:0]     next_idx;
  logic [RC_W-1:0]      next_row;
  logic [RC_W-1:0]      next_col;
  logic [ACC_WIDTH-1:0] sel_acc;
  logic [SH_W-1:0]      sel_shift;
  logic [OUT_WIDTH-1:0] rq_data;
  logic                 rq_sat;

  assign busy = (state == DRAIN);

  // Pick the element that will be presented next: element 0 straight from the
  // live bank on capture (snapshot not yet written), otherwise the snapshot.
  always_comb begin
    next_idx  = (idx == IDX_W'(NUM - 1)) ? '0 : idx + 1'b1;
    next_col  = (out_col == RC_W'(N - 1)) ? '0 : out_col + 1'b1;
    next_row  = (out_col == RC_W'(N - 1)) ? out_row + 1'b1 : out_row;
    sel_acc   = snap[next_idx];
    sel_shift = snap_shift;
    if (state == IDLE) begin
      sel_acc   = acc_out_flat[ACC_WIDTH-1:0];
      sel_shift = shift_amt;
    end
  end

  requant_sat #(
    .ACC_WIDTH   (ACC_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT_WIDTH (SH_W)
  ) u_requant_sat (
    .acc   (sel_acc),
    .shift (sel_shift),
    .data  (rq_data),
    .sat   (rq_sat)
  );

  // Snapshot bank: loaded only when a capture is accepted.
  always_ff @(posedge clk) begin
    // NOTE: the bank is deliberately left out of reset; it is always written
    // before it is read, and a reset would cost a mux on every bit.
    if (state == IDLE && capture) begin
      for (int i = 0; i < NUM; i++) begin
        snap[i] <= acc_out_flat[i*ACC_WIDTH +: ACC_WIDTH];
      end
      snap_shift <= shift_amt;
    end
  end

  // Drain FSM with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values regardless of statement order.
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_last     <= 1'b0;
      out_sat      <= 1'b0;
      done         <= 1'b0;
      capture_drop <= 1'b0;
    end else begin
      done         <= 1'b0;
      capture_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            state     <= DRAIN;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= rq_data;
            out_sat   <= rq_sat;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= (NUM == 1);
          end
        end
        DRAIN: begin
          if (capture) capture_drop <= 1'b1;
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              idx       <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_row   <= '0;
              out_col   <= '0;
              out_last  <= 1'b0;
              out_sat   <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx      <= next_idx;
              out_data <= rq_data;
              out_sat  <= rq_sat;
              out_row  <= next_row;
              out_col  <= next_col;
              out_last <= (next_idx == IDX_W'(NUM - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_drain_unit.sv
// Self-checking bench for acc_drain_unit (N=3, 32-bit accumulators, 8-bit out).
module tb_acc_drain_unit;

  localparam int N   = 3;
  localparam int NUM = 9;
  localparam int AW  = 32;
  localparam int OW  = 8;
  localparam int SW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW*NUM-1:0] acc_out_flat;
  logic              capture;
  logic [SW-1:0]     shift_amt;
  logic              out_ready;
  logic              out_valid;
  logic [OW-1:0]     out_data;
  logic [1:0]        out_row;
  logic [1:0]        out_col;
  logic              out_last;
  logic              out_sat;
  logic              busy;
  logic              done;
  logic              capture_drop;

  acc_drain_unit #(
    .DATA_WIDTH  (8),
    .MATRIX_SIZE (N),
    .ACC_WIDTH   (AW),
    .OUT_WIDTH   (OW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .acc_out_flat (acc_out_flat),
    .capture      (capture),
    .shift_amt    (shift_amt),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last     (out_last),
    .out_sat      (out_sat),
    .busy         (busy),
    .done         (done),
    .capture_drop (capture_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
    logic       sat;
  } exp_t;

  typedef struct {
    longint     acc;
    int         sh;
    logic [7:0] exp_data;
    bit         exp_sat;
  } tv_t;

  exp_t   exp_q[$];
  int     total, bad;
  int     xfers, dones, drops, vcyc;
  int     bx, bd, bdr, bv;
  bit     last_pend, prev_stall;
  exp_t   held;
  tv_t    tv [10];
  longint m [9];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference requantizer: round half up, arithmetic shift, clamp to int8.
  function automatic exp_t model(input longint acc, input int sh, input int r, input int c);
    longint v;
    exp_t   e;
    if (sh == 0) v = acc;
    else         v = (acc + (longint'(1) << (sh - 1))) >>> sh;
    e.sat = 1'b0;
    if (v > 127) begin
      v = 127;  e.sat = 1'b1;
    end else if (v < -128) begin
      v = -128; e.sat = 1'b1;
    end
    e.data = v[7:0];
    e.row  = r[1:0];
    e.col  = c[1:0];
    e.last = (r == N - 1) && (c == N - 1);
    return e;
  endfunction

  // Observes the DUT mid-cycle; every handshake pops the scoreboard.
  task automatic monitor();
    exp_t cur, e;
    forever begin
      @(negedge clk);
      cur = '{out_data, out_row, out_col, out_last, out_sat};
      if (!rst) begin
        prev_stall = 1'b0;
        last_pend  = 1'b0;
      end else begin
        if (last_pend) begin
          check("done_pulse", done, 1);
          check("busy_after_done", busy, 0);
          check("valid_after_done", out_valid, 0);
          last_pend = 1'b0;
        end
        if (prev_stall) check("hold_while_stalled", cur, held);
        if (out_valid) vcyc++;
        if (done) dones++;
        if (capture_drop) drops++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("xfer_queue_depth", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("xfer_data", out_data, e.data);
            check("xfer_row_col_last_sat", cur[5:0], e[5:0]);
          end
          xfers++;
          if (out_last) last_pend = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        held       = cur;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_sat"}, out_sat, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_drop"}, capture_drop, 0);
  endtask

  task automatic scramble_bank();
    for (int i = 0; i < NUM; i++) acc_out_flat[i*AW +: AW] = $urandom;
    shift_amt = SW'($urandom);
  endtask

  task automatic do_capture(input longint mat [9], input int sh);
    @(posedge clk); #1;
    for (int i = 0; i < NUM; i++) acc_out_flat[i*AW +: AW] = mat[i][AW-1:0];
    shift_amt = SW'(sh);
    capture   = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back(model(mat[r*N+c], sh, r, c));
    @(posedge clk); #1;
    capture = 1'b0;
    scramble_bank();
    check("capture_latency_valid", out_valid, 1);
    check("capture_busy", busy, 1);
    check("capture_first_rowcol", {out_row, out_col}, 0);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic drain(input int mode, input bit drop_mid, input bit drop_last);
    int cyc = 0;
    bit fin = 1'b0;
    while (!fin && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      capture   = (drop_mid && cyc == 3) || (drop_last && out_last && out_ready);
      if (capture) scramble_bank();
      @(posedge clk); #1;
      capture = 1'b0;
      if (!busy) fin = 1'b1;
      cyc++;
    end
    if (!fin) check("drain_timeout", cyc, 0);
    out_ready = 1'b1;
  endtask

  task automatic mark();
    bx = xfers; bd = dones; bdr = drops; bv = vcyc;
  endtask

  task automatic end_checks(input int ex, input int ed, input int edr, input int ev);
    @(negedge clk); #1;
    check("xfer_count", xfers - bx, ex);
    check("done_count", dones - bd, ed);
    check("drop_count", drops - bdr, edr);
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    if (ev >= 0) check("valid_cycles", vcyc - bv, ev);
  endtask

  initial begin
    rst = 1'b0; capture = 1'b0; out_ready = 1'b0; shift_amt = '0;
    acc_out_flat = '0;
    total = 0; bad = 0; xfers = 0; dones = 0; drops = 0; vcyc = 0;
    last_pend = 1'b0; prev_stall = 1'b0; held = '0;

    tv[0] = '{90, 2, 8'd23, 1'b0};
    tv[1] = '{-6, 2, 8'hFF, 1'b0};
    tv[2] = '{5, 1, 8'd3, 1'b0};
    tv[3] = '{1000, 0, 8'd127, 1'b1};
    tv[4] = '{-1000, 0, 8'h80, 1'b1};
    tv[5] = '{127, 0, 8'd127, 1'b0};
    tv[6] = '{-129, 0, 8'h80, 1'b1};
    tv[7] = '{255, 1, 8'd127, 1'b1};
    tv[8] = '{2147483647, 31, 8'd1, 1'b0};
    tv[9] = '{-64'sd2147483648, 31, 8'hFF, 1'b0};

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // Plain drain, ready high, no saturation.
    out_ready = 1'b1;
    mark();
    m = '{10, 20, 30, 20, 40, 60, 30, 60, 90};
    do_capture(m, 0);
    drain(0, 1'b0, 1'b0);
    end_checks(9, 1, 0, 9);

    // Requantization table applied through element (0,0).
    for (int i = 0; i < 10; i++) begin
      mark();
      m = '{tv[i].acc, -1000, 127, 0, 1, -1, 300, -300, 64};
      do_capture(m, tv[i].sh);
      check("tv_data", out_data, tv[i].exp_data);
      check("tv_sat", out_sat, tv[i].exp_sat);
      drain(0, 1'b0, 1'b0);
      end_checks(9, 1, 0, 9);
    end

    // Back-pressure: output must hold while stalled.
    mark();
    m = '{-3, 7, 500, -501, 2, 9, -9, 11, 254};
    do_capture(m, 1);
    drain(1, 1'b0, 1'b0);
    end_checks(9, 1, 0, -1);
    check("stall_extends_valid", (vcyc - bv) > 9, 1);

    // Captures during drain and on the final transfer are dropped.
    mark();
    m = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    do_capture(m, 0);
    drain(0, 1'b1, 1'b1);
    end_checks(9, 1, 2, 9);

    // Reset after the fourth transfer abandons the drain.
    mark();
    m = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
    do_capture(m, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("mid_reset");
    check("xfers_before_reset", xfers - bx, 4);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    check("no_done_after_reset", dones - bd, 0);
    check("post_reset_busy", busy, 0);
    mark();
    m = '{-20, 40, -60, 80, -100, 120, -140, 160, -180};
    do_capture(m, 0);
    drain(0, 1'b0, 1'b0);
    end_checks(9, 1, 0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
